// File: rtl/alu_seq_mul_if.sv
// ============================================================================
// Module      : alu_seq_mul_if
// Description : Request/result and external-ALU bus bundle for alu_seq_mul.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_mul_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] mulA;
    logic [WIDTH-1:0] mulB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod;
    logic             ovf;
    logic             prodZer;
    logic             prodNeg;
    logic [2:0]       aluOpc;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic             aluC;
    logic [WIDTH-1:0] aluW;
    logic             aluZer;
    logic             aluNeg;

    // The multiplier sits on the slave side; the master issues jobs and hosts the ALU.
    modport slave (
        input  start, mulA, mulB, aluW, aluZer, aluNeg,
        output busy, done, prod, ovf, prodZer, prodNeg, aluOpc, aluA, aluB, aluC
    );

    modport master (
        output start, mulA, mulB, aluW, aluZer, aluNeg,
        input  busy, done, prod, ovf, prodZer, prodNeg, aluOpc, aluA, aluB, aluC
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq_mul.sv
// ============================================================================
// Module      : alu_seq_mul
// Description : Sequential signed multiplier using an external ALU as datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_mul_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] C_IDLE = 4'd0;
    localparam logic [3:0] C_NEGA = 4'd1;
    localparam logic [3:0] C_INCA = 4'd2;
    localparam logic [3:0] C_NEGB = 4'd3;
    localparam logic [3:0] C_INCB = 4'd4;
    localparam logic [3:0] C_LOOP = 4'd5;
    localparam logic [3:0] C_FIXN = 4'd6;
    localparam logic [3:0] C_FIXI = 4'd7;
    localparam logic [3:0] C_DONE = 4'd8;

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_INC  = 3'b001;
    localparam logic [2:0] C_OP_NOT  = 3'b110;
    localparam logic [2:0] C_OP_ZERO = 3'b111;

    localparam logic [CW-1:0]    C_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [3:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             mag_ovf_q, mag_ovf_d;
    logic             a_lost_q, a_lost_d;
    logic             fix_ovf_q, fix_ovf_d;
    logic             ovf_q, ovf_d, zer_q, zer_d, neg_q, neg_d;

    logic [2:0]       w_opc;
    logic [WIDTH-1:0] w_a, w_b;
    logic             w_mag_ovf, w_ovf;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        mag_ovf_d = mag_ovf_q;
        a_lost_d  = a_lost_q;
        fix_ovf_d = fix_ovf_q;
        prod_d    = prod_q;
        ovf_d     = ovf_q;
        zer_d     = zer_q;
        neg_d     = neg_q;
        w_opc     = C_OP_ZERO;
        w_a       = '0;
        w_b       = '0;
        w_mag_ovf = 1'b0;
        w_ovf     = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (bus.start) begin
                    a_d       = bus.mulA;
                    b_d       = bus.mulB;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sgn_d     = bus.mulA[WIDTH-1] ^ bus.mulB[WIDTH-1];
                    mag_ovf_d = 1'b0;
                    a_lost_d  = 1'b0;
                    fix_ovf_d = 1'b0;
                    if (bus.mulA[WIDTH-1])      state_d = C_NEGA;
                    else if (bus.mulB[WIDTH-1]) state_d = C_NEGB;
                    else                        state_d = C_LOOP;
                end
            end
            C_NEGA: begin
                w_opc   = C_OP_NOT;
                w_a     = a_q;
                a_d     = bus.aluW;
                state_d = C_INCA;
            end
            C_INCA: begin
                w_opc   = C_OP_INC;
                w_a     = a_q;
                a_d     = bus.aluW;
                // b still holds the raw multiplier here, so its MSB is the sign of mulB
                state_d = b_q[WIDTH-1] ? C_NEGB : C_LOOP;
            end
            C_NEGB: begin
                w_opc   = C_OP_NOT;
                w_a     = b_q;
                b_d     = bus.aluW;
                state_d = C_INCB;
            end
            C_INCB: begin
                w_opc   = C_OP_INC;
                w_a     = b_q;
                b_d     = bus.aluW;
                state_d = C_LOOP;
            end
            C_LOOP: begin
                w_opc     = C_OP_ADD;
                w_a       = acc_q;
                w_b       = b_q[0] ? a_q : '0;
                acc_d     = bus.aluW;
                a_d       = a_q << 1;
                b_d       = b_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                // Adding a shifted-out multiplicand bit or wrapping the sum both lose magnitude
                w_mag_ovf = mag_ovf_q | (b_q[0] & (a_lost_q | (bus.aluW < acc_q)));
                mag_ovf_d = w_mag_ovf;
                if (a_q[WIDTH-1]) a_lost_d = 1'b1;
                w_ovf     = w_mag_ovf | (bus.aluW[WIDTH-1] & ~(sgn_q & (bus.aluW == C_MIN)));
                if (cnt_q == C_LAST) begin
                    if (sgn_q) begin
                        fix_ovf_d = w_ovf;
                        state_d   = C_FIXN;
                    end else begin
                        prod_d  = bus.aluW;
                        ovf_d   = w_ovf;
                        zer_d   = bus.aluZer;
                        neg_d   = bus.aluNeg;
                        state_d = C_DONE;
                    end
                end
            end
            C_FIXN: begin
                w_opc   = C_OP_NOT;
                w_a     = acc_q;
                acc_d   = bus.aluW;
                state_d = C_FIXI;
            end
            C_FIXI: begin
                w_opc   = C_OP_INC;
                w_a     = acc_q;
                acc_d   = bus.aluW;
                prod_d  = bus.aluW;
                ovf_d   = fix_ovf_q;
                zer_d   = bus.aluZer;
                neg_d   = bus.aluNeg;
                state_d = C_DONE;
            end
            C_DONE:  state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= C_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            mag_ovf_q <= 1'b0;
            a_lost_q  <= 1'b0;
            fix_ovf_q <= 1'b0;
            prod_q    <= '0;
            ovf_q     <= 1'b0;
            zer_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            mag_ovf_q <= mag_ovf_d;
            a_lost_q  <= a_lost_d;
            fix_ovf_q <= fix_ovf_d;
            prod_q    <= prod_d;
            ovf_q     <= ovf_d;
            zer_q     <= zer_d;
            neg_q     <= neg_d;
        end
    end

    assign bus.busy    = (state_q != C_IDLE);
    assign bus.done    = (state_q == C_DONE);
    assign bus.prod    = prod_q;
    assign bus.ovf     = ovf_q;
    assign bus.prodZer = zer_q;
    assign bus.prodNeg = neg_q;
    assign bus.aluOpc  = w_opc;
    assign bus.aluA    = w_a;
    assign bus.aluB    = w_b;
    assign bus.aluC    = 1'b0;
endmodule

`default_nettype wire

// File: tb/tb_alu_seq_mul.sv
// ============================================================================
// Module      : tb_alu_seq_mul
// Description : Directed vector bench for alu_seq_mul with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_mul;
    logic clk;
    logic rst;

    alu_seq_mul_if #(.WIDTH(16)) bus ();

    alu_seq_mul #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU
    always_comb begin
        case (bus.aluOpc)
            3'b000:  bus.aluW = bus.aluA + bus.aluB + {15'd0, bus.aluC};
            3'b001:  bus.aluW = bus.aluA + 16'd1;
            3'b110:  bus.aluW = ~bus.aluA;
            default: bus.aluW = '0;
        endcase
    end
    assign bus.aluZer = (bus.aluW == 16'd0);
    assign bus.aluNeg = bus.aluW[15];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_prod;
        logic        exp_ovf;
        logic        exp_zer;
        logic        exp_neg;
        int          exp_lat;
    } vec_t;

    vec_t       vecs [12];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] opc_trace [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at cycle index 'first' (#1 after an edge); returns the cycle done was seen, 0 on timeout.
    task automatic wait_done(input int first, output int lat);
        lat = 0;
        for (int i = first; i <= 60 && lat == 0; i++) begin
            if (i >= 1 && i <= 4) opc_trace[i-1] = bus.aluOpc;
            if (bus.done) lat = i;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.mulA  = a;
        bus.mulB  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0]  = '{16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 17};
        vecs[1]  = '{16'hFFFD, 16'h0005, 16'hFFF1, 1'b0, 1'b0, 1'b1, 21};
        vecs[2]  = '{16'hFFFC, 16'hFFFC, 16'h0010, 1'b0, 1'b0, 1'b0, 21};
        vecs[3]  = '{16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 17};
        vecs[4]  = '{16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 21};
        vecs[5]  = '{16'hFFFF, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1, 21};
        vecs[6]  = '{16'h0000, 16'hFFFB, 16'h0000, 1'b0, 1'b1, 1'b0, 21};
        vecs[7]  = '{16'h00C8, 16'h00C8, 16'h9C40, 1'b1, 1'b0, 1'b1, 17};
        vecs[8]  = '{16'h0007, 16'hFFFF, 16'hFFF9, 1'b0, 1'b0, 1'b1, 21};
        vecs[9]  = '{16'h00B5, 16'h00B5, 16'h7FF9, 1'b0, 1'b0, 1'b0, 17};
        vecs[10] = '{16'hFF4B, 16'h00B5, 16'h8007, 1'b0, 1'b0, 1'b1, 21};
        vecs[11] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 17};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mulA  = '0;
        bus.mulB  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_prod", bus.prod, 16'h0000);
        check("rst_ovf", 16'(bus.ovf), 16'd0);
        check("rst_zer", 16'(bus.prodZer), 16'd0);
        check("rst_neg", 16'(bus.prodNeg), 16'd0);
        check("rst_opc", 16'(bus.aluOpc), 16'h0007);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 12; k++) begin
            launch(vecs[k].a, vecs[k].b);
            check("busy_c1", 16'(bus.busy), 16'd1);
            wait_done(1, lat);
            check("latency", 16'(lat), 16'(vecs[k].exp_lat));
            check("prod", bus.prod, vecs[k].exp_prod);
            check("ovf", 16'(bus.ovf), 16'(vecs[k].exp_ovf));
            check("prodZer", 16'(bus.prodZer), 16'(vecs[k].exp_zer));
            check("prodNeg", 16'(bus.prodNeg), 16'(vecs[k].exp_neg));
            if (k == 2) begin
                check("opc_nega", 16'(opc_trace[0]), 16'h0006);
                check("opc_inca", 16'(opc_trace[1]), 16'h0001);
                check("opc_negb", 16'(opc_trace[2]), 16'h0006);
                check("opc_incb", 16'(opc_trace[3]), 16'h0001);
            end
            @(posedge clk);
            #1;
            check("done_pulse", 16'(bus.done), 16'd0);
            check("idle_busy", 16'(bus.busy), 16'd0);
            check("prod_held", bus.prod, vecs[k].exp_prod);
            check("idle_opc", 16'(bus.aluOpc), 16'h0007);
        end

        // start during DONE is ignored, then accepted in the following IDLE cycle
        launch(16'h0002, 16'h0003);
        wait_done(1, lat);
        check("d_prod", bus.prod, 16'h0006);
        bus.start = 1'b1;
        bus.mulA  = 16'h0002;
        bus.mulB  = 16'h0002;
        @(posedge clk);
        #1;
        check("d_start_ign", 16'(bus.busy), 16'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", 16'(bus.busy), 16'd1);
        wait_done(1, lat);
        check("b2b_lat", 16'(lat), 16'd17);
        check("b2b_prod", bus.prod, 16'h0004);
        @(posedge clk);
        #1;

        // start during LOOP must not disturb the running job
        launch(16'h0003, 16'h0005);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.mulA  = 16'h0009;
        bus.mulB  = 16'hFFF7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("loop_busy", 16'(bus.busy), 16'd1);
        wait_done(6, lat);
        check("loop_lat", 16'(lat), 16'd17);
        check("loop_prod", bus.prod, 16'h000F);
        check("loop_neg", 16'(bus.prodNeg), 16'd0);
        @(posedge clk);
        #1;

        // rst at LOOP count 8 (cycle 9) aborts to IDLE with reset values
        launch(16'h0003, 16'h0005);
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_busy", 16'(bus.busy), 16'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 16'(bus.busy), 16'd0);
        check("abort_done", 16'(bus.done), 16'd0);
        check("abort_prod", bus.prod, 16'h0000);
        check("abort_opc", 16'(bus.aluOpc), 16'h0007);
        @(posedge clk);
        #1;
        launch(16'hFFFD, 16'h0005);
        wait_done(1, lat);
        check("post_rst_lat", 16'(lat), 16'd21);
        check("post_rst_prod", bus.prod, 16'hFFF1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
